// File: rtl/vdc_crtc_timing.sv
// Raster timing generator for the VDC: divides the dot-clock enable into characters,
// columns, scanlines, rows and fields, with interlace, sync, display-enable and blink.
module vdc_crtc_timing #(
    parameter int CW         = 8,
    parameter int LW         = 5,
    parameter int BLINK_FAST = 16,
    parameter int BLINK_SLOW = 30
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enable,
    input  logic          init,
    input  logic [CW-1:0] reg_ht,
    input  logic [CW-1:0] reg_hd,
    input  logic [CW-1:0] reg_hp,
    input  logic [3:0]    reg_hw,
    input  logic [3:0]    reg_vw,
    input  logic [CW-1:0] reg_vt,
    input  logic [CW-1:0] reg_vd,
    input  logic [CW-1:0] reg_vp,
    input  logic [LW-1:0] reg_va,
    input  logic [LW-1:0] reg_ctv,
    input  logic [3:0]    reg_cth,
    input  logic [1:0]    reg_im,
    output logic          newCol,
    output logic          endCol,
    output logic          newLine,
    output logic          newRow,
    output logic [1:0]    newFrame,
    output logic [CW-1:0] col,
    output logic [CW-1:0] row,
    output logic [LW-1:0] line,
    output logic          field,
    output logic          hde,
    output logic          vde,
    output logic          hsync,
    output logic          vsync,
    output logic [1:0]    blink
);

    localparam logic [1:0] ST_ACTIVE    = 2'd0;
    localparam logic [1:0] ST_ADJUST    = 2'd1;
    localparam logic [1:0] ST_FRAME_END = 2'd2;

    logic [3:0]    dot, dot_d;
    logic [1:0]    state, state_d;
    logic [LW:0]   adj, adj_d;
    logic [4:0]    hcnt, hcnt_d;
    logic [4:0]    vcnt, vcnt_d;
    logic          vwin, vwin_d;
    logic [15:0]   bf_cnt, bf_d;
    logic [15:0]   bs_cnt, bs_d;

    logic [CW-1:0] col_d, row_d;
    logic [LW-1:0] line_d;
    logic          field_d, hsync_d, vsync_d, hde_d, vde_d;
    logic [1:0]    blink_d, new_frame_d;
    logic          new_col_d, end_col_d, new_line_d, new_row_d;
    logic          col_start, row_start, frame_end;

    logic          interlace, vid_il, row_wrap;
    logic [4:0]    hw_full, vw_full;
    logic [LW:0]   adj_total;
    logic [LW-1:0] line_step;
    logic [CW-1:0] ht_inc, half_col;

    assign interlace = reg_im[0];
    assign vid_il    = (reg_im == 2'b11);
    assign hw_full   = (reg_hw == 4'd0) ? 5'd16 : {1'b0, reg_hw};
    assign vw_full   = (reg_vw == 4'd0) ? 5'd16 : {1'b0, reg_vw};
    // Odd interlace fields carry one extra adjust scanline.
    assign adj_total = {1'b0, reg_va} + {{LW{1'b0}}, interlace & field};
    assign line_step = vid_il ? LW'(2) : LW'(1);
    assign ht_inc    = reg_ht + 1'b1;
    assign half_col  = ht_inc >> 1;
    // In sync+video interlace each field only visits every other scanline of a row.
    assign row_wrap  = vid_il ? (({1'b0, line} + (LW+1)'(2)) > {1'b0, reg_ctv})
                              : (line >= reg_ctv);

    // Next-state computation for all counters, strobes and sync outputs.
    always_comb begin
        dot_d       = dot;
        state_d     = state;
        adj_d       = adj;
        hcnt_d      = hcnt;
        vcnt_d      = vcnt;
        vwin_d      = vwin;
        bf_d        = bf_cnt;
        bs_d        = bs_cnt;
        col_d       = col;
        row_d       = row;
        line_d      = line;
        field_d     = field;
        hsync_d     = hsync;
        vsync_d     = vsync;
        hde_d       = hde;
        vde_d       = vde;
        blink_d     = blink;
        new_col_d   = 1'b0;
        end_col_d   = 1'b0;
        new_line_d  = 1'b0;
        new_row_d   = 1'b0;
        new_frame_d = 2'b00;
        col_start   = 1'b0;
        row_start   = 1'b0;
        frame_end   = 1'b0;

        if (enable) begin
            if (state == ST_FRAME_END) state_d = ST_ACTIVE;

            if (dot == 4'd0) begin
                dot_d     = reg_cth;
                col_start = 1'b1;
            end else begin
                dot_d = dot - 4'd1;
            end
            end_col_d = (dot_d == 4'd0);
            new_col_d = col_start;

            // >= so that shrinking reg_ht below the current column wraps at once.
            if (col_start) begin
                if (col >= reg_ht) begin
                    col_d      = '0;
                    new_line_d = 1'b1;
                end else begin
                    col_d = col + 1'b1;
                end
            end

            if (new_line_d) begin
                if (state == ST_ADJUST) begin
                    if ((adj + 1'b1) >= adj_total) frame_end = 1'b1;
                    else adj_d = adj + 1'b1;
                end else if (row_wrap) begin
                    new_row_d = 1'b1;
                    line_d    = vid_il ? {{(LW-1){1'b0}}, field} : '0;
                    if (row >= reg_vt) begin
                        if (adj_total == '0) begin
                            frame_end = 1'b1;
                        end else begin
                            state_d = ST_ADJUST;
                            adj_d   = '0;
                        end
                    end else begin
                        row_d     = row + 1'b1;
                        row_start = 1'b1;
                    end
                end else begin
                    line_d = line + line_step;
                end
            end

            if (frame_end) begin
                field_d     = interlace ? ~field : 1'b0;
                row_d       = '0;
                line_d      = vid_il ? {{(LW-1){1'b0}}, field_d} : '0;
                state_d     = ST_FRAME_END;
                row_start   = 1'b1;
                new_frame_d = interlace ? {~field_d, field_d} : 2'b11;
                if (bf_cnt == 16'(BLINK_FAST - 1)) begin
                    bf_d       = '0;
                    blink_d[0] = ~blink[0];
                end else begin
                    bf_d = bf_cnt + 1'b1;
                end
                if (bs_cnt == 16'(BLINK_SLOW - 1)) begin
                    bs_d       = '0;
                    blink_d[1] = ~blink[1];
                end else begin
                    bs_d = bs_cnt + 1'b1;
                end
            end

            // hsync counts columns; hitting reg_hp again restarts the pulse.
            if (col_start) begin
                if (col_d == reg_hp) begin
                    hsync_d = 1'b1;
                    hcnt_d  = 5'd1;
                end else if (hsync) begin
                    if (hcnt >= hw_full) hsync_d = 1'b0;
                    else hcnt_d = hcnt + 5'd1;
                end
            end

            // vsync window is counted in scanlines from the first line of row reg_vp.
            if (new_line_d) begin
                if (row_start && (row_d == reg_vp)) begin
                    vwin_d = 1'b1;
                    vcnt_d = 5'd1;
                end else if (vwin) begin
                    if (vcnt >= vw_full) vwin_d = 1'b0;
                    else vcnt_d = vcnt + 5'd1;
                end
            end

            // Odd interlace fields shift the vsync edges by half a line.
            if (col_start && (!(interlace && field_d) || (col_d == half_col))) begin
                vsync_d = vwin_d;
            end

            hde_d = (col_d < reg_hd);
            vde_d = (state_d != ST_ADJUST) && (row_d < reg_vd);
        end
    end

    // State and output registers; reset and init both restart the frame.
    always_ff @(posedge clk) begin
        if (reset || init) begin
            dot      <= reg_cth;
            state    <= ST_ACTIVE;
            adj      <= '0;
            hcnt     <= '0;
            vcnt     <= '0;
            vwin     <= 1'b0;
            bf_cnt   <= '0;
            bs_cnt   <= '0;
            col      <= '0;
            row      <= '0;
            line     <= '0;
            field    <= 1'b0;
            hsync    <= 1'b0;
            vsync    <= 1'b0;
            hde      <= 1'b1;
            vde      <= 1'b1;
            blink    <= 2'b00;
            newCol   <= 1'b0;
            endCol   <= 1'b0;
            newLine  <= 1'b0;
            newRow   <= 1'b0;
            newFrame <= 2'b00;
        end else begin
            dot      <= dot_d;
            state    <= state_d;
            adj      <= adj_d;
            hcnt     <= hcnt_d;
            vcnt     <= vcnt_d;
            vwin     <= vwin_d;
            bf_cnt   <= bf_d;
            bs_cnt   <= bs_d;
            col      <= col_d;
            row      <= row_d;
            line     <= line_d;
            field    <= field_d;
            hsync    <= hsync_d;
            vsync    <= vsync_d;
            hde      <= hde_d;
            vde      <= vde_d;
            blink    <= blink_d;
            newCol   <= new_col_d;
            endCol   <= end_col_d;
            newLine  <= new_line_d;
            newRow   <= new_row_d;
            newFrame <= new_frame_d;
        end
    end

endmodule

// File: doc/vdc_crtc_timing.md
# vdc_crtc_timing

Parametrised raster timing generator for the VDC, successor to the fixed-width clock generator. It divides the dot-clock enable into characters, columns, scanlines, rows and fields, and adds real interlace support (sync-only and sync+video modes with field parity). It also drives sync, display-enable and blink outputs for the VDC fetch and pixel pipelines. Register inputs come straight from the VDC register file and are sampled live.

## Interface
- CW, 8: width of column/row counters and the R0/R1/R2/R4/R6/R7 inputs
- LW, 5: width of the character-line counter and the R5/R9 inputs
- BLINK_FAST, 16: frames per toggle of blink[0]
- BLINK_SLOW, 30: frames per toggle of blink[1]
- clk  in  1  system clock
- reset  in  1  synchronous, active-high; clock clk
- enable  in  1  dot-clock enable; all counters advance only when high
- init  in  1  synchronous restart to frame start; same effect as reset
- reg_ht, reg_hd, reg_hp  in  CW  horizontal total−1, displayed, sync position
- reg_hw, reg_vw  in  4  hsync width in columns, vsync width in scanlines; 0 means 16
- reg_vt, reg_vd, reg_vp  in  CW  vertical total−1 (rows), displayed rows, vsync row
- reg_va  in  LW  vertical total adjust (scanlines)
- reg_ctv  in  LW  scanlines per row −1
- reg_cth  in  4  dots per column −1
- reg_im  in  2  00/10 progressive, 01 interlace sync, 11 interlace sync+video
- newCol, endCol, newLine, newRow  out  1  strobes
- newFrame  out  2  11 progressive, 01 odd field, 10 even field
- col, row  out  CW  current column and row
- line  out  LW  current scanline within row
- field  out  1  current field (0 even, 1 odd)
- hde, vde  out  1  horizontal / vertical display enable
- hsync, vsync  out  1  sync outputs
- blink  out  2  blink[0] fast, blink[1] slow

## Operation
- Dot counter: loads reg_cth at column start and decrements per enable. endCol fires when it equals 0. newCol fires when it reloads. With reg_cth=0 both fire every enable.
- Column: col increments at each column start. At col >= reg_ht it wraps to 0 and newLine fires. Using >= makes a mid-line shrink of reg_ht wrap immediately.
- Line: in progressive and im=01 modes, line runs 0..reg_ctv with step 1. In im=11, line starts at field and steps by 2, and the row ends when line+2 > reg_ctv. newRow fires when line wraps.
- Row: row runs 0..reg_vt. After row reg_vt, the generator enters ADJUST for reg_va scanlines, then ends the frame. In interlace modes, an odd field adds 1 extra adjust scanline.
- States: ACTIVE (rows 0..reg_vt), ADJUST (counts reg_va(+1) scanlines), FRAME_END (single-cycle transition). ADJUST is skipped when its count is 0.
- Frame end: col, row and line reset to 0. field toggles if reg_im[0]=1, otherwise it is forced to 0. newFrame is 11 in progressive mode, or {~field_new, field_new} in interlace modes.
- hsync: asserted from col == reg_hp for reg_hw columns (16 if reg_hw=0), wrapping across the line end.
- vsync: starts at line 0 of row reg_vp and lasts reg_vw scanlines (16 if reg_vw=0). In odd interlace fields it starts and ends at col == (reg_ht+1)>>1 of those scanlines.
- hde = col < reg_hd. vde = row < reg_vd and state is ACTIVE.
- Blink counters advance on every nonzero newFrame. blink[0] toggles every BLINK_FAST frames and blink[1] every BLINK_SLOW frames.
- Arithmetic is modulo counter width. No multipliers; all totals are counted hierarchically.

## Timing
- All outputs are registered and update on the clk edge where enable=1.
- Strobes are high for exactly one clk cycle following that edge, and low on clk cycles without enable.
- Reset/init values: all strobes 0, col=row=line=0, field=0, hsync=0, vsync=0, hde=1, vde=1, blink=00, dot counter = reg_cth.
- The first newCol comes 1 enable after reset release when reg_cth=0, or after reg_cth+1 enables otherwise.
- Simultaneous frame end and row end: newRow, newLine and newFrame all fire in the same cycle.
- Register changes take effect at the next comparison; no shadowing.
- reset or init mid-frame aborts immediately, with no strobes that cycle.

## Test plan
- Progressive, reg_cth=7, reg_ht=9, reg_ctv=1, reg_vt=2, reg_va=0: newCol every 8 enables, newLine every 80, newRow every 160, newFrame=11 every 480.
- reg_hp=5, reg_hw=0: hsync high exactly 16 columns starting col 5, wrapping over col 0. With reg_hw=3 it is high for 3 columns.
- reg_va=2, reg_vd=2: vde low during row 2 and both adjust scanlines. The frame has (reg_vt+1)*(reg_ctv+1)+2 lines.
- im=11, reg_ctv=3: line sequence 0,2 in even fields and 1,3 in odd fields. newFrame alternates 10/01. Odd-field vsync edge lands at col (reg_ht+1)>>1.
- 30 frames at reg_cth=0: blink[0] toggles at frames 16 and 32 (count only to 30, so one toggle). blink[1] toggles at frame 30.
- init pulsed mid-line at col 4: next cycle col=0, row=0, no strobe. reg_ht lowered below col gives an immediate wrap with newLine.
